// File: rtl/rs_issue_scheduler.sv
// Reservation-station array: allocation with same-cycle CDB bypass, per-cycle wakeup,
// exact age matrix, and oldest-ready issue to two registered FU ports (ALU, MEM).
module rs_issue_scheduler #(
    parameter int RS_SIZE = 8,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic                         alloc_valid_i,
    output logic                         alloc_ready_o,
    input  logic                         alloc_fu_i,
    input  logic [TAG_W-1:0]             alloc_tag_i,
    input  logic [TAG_W-1:0]             alloc_tag_1_i,
    input  logic [TAG_W-1:0]             alloc_tag_2_i,
    input  logic [DATA_W-1:0]            alloc_value_1_i,
    input  logic [DATA_W-1:0]            alloc_value_2_i,
    input  logic [DATA_W-1:0]            alloc_imm_i,
    input  logic [CTRL_W-1:0]            alloc_ctrl_i,
    input  logic [TAG_W-1:0]             cdb_tag_1_i,
    input  logic [TAG_W-1:0]             cdb_tag_2_i,
    input  logic [DATA_W-1:0]            cdb_value_1_i,
    input  logic [DATA_W-1:0]            cdb_value_2_i,
    output logic                         alu_valid_o,
    input  logic                         alu_ready_i,
    output logic [TAG_W-1:0]             alu_tag_o,
    output logic [DATA_W-1:0]            alu_value_1_o,
    output logic [DATA_W-1:0]            alu_value_2_o,
    output logic [DATA_W-1:0]            alu_imm_o,
    output logic [CTRL_W-1:0]            alu_ctrl_o,
    output logic                         mem_valid_o,
    input  logic                         mem_ready_i,
    output logic [TAG_W-1:0]             mem_tag_o,
    output logic [DATA_W-1:0]            mem_value_1_o,
    output logic [DATA_W-1:0]            mem_value_2_o,
    output logic [DATA_W-1:0]            mem_imm_o,
    output logic [CTRL_W-1:0]            mem_ctrl_o,
    output logic [$clog2(RS_SIZE+1)-1:0] free_count_o
);
    localparam int CNT_W = $clog2(RS_SIZE+1);
    localparam int NFU   = 2;  // port 0 = ALU, port 1 = MEM

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } opnd_t;

    typedef struct packed {
        logic              fu;
        logic [TAG_W-1:0]  tag;
        opnd_t             op1;
        opnd_t             op2;
        logic [DATA_W-1:0] imm;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
        logic [DATA_W-1:0] imm;
        logic [CTRL_W-1:0] ctrl;
    } issue_t;

    // CDB port 1 wins when both ports carry the awaited tag.
    function automatic opnd_t snoop(input opnd_t o,
                                    input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2,
                                    input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2);
        opnd_t r;
        r = o;
        if (o.tag != '0) begin
            if (o.tag == t1)      r = '{tag: '0, val: d1};
            else if (o.tag == t2) r = '{tag: '0, val: d2};
        end
        return r;
    endfunction

    entry_t                            ent_q [RS_SIZE];
    entry_t                            ent_d [RS_SIZE];
    logic [RS_SIZE-1:0]                busy_q, busy_d;
    logic [RS_SIZE-1:0][RS_SIZE-1:0]   older_q, older_d, older_t;
    logic [CNT_W-1:0]                  free_q, free_d;
    logic [NFU-1:0]                    vld_q, vld_d, fu_rdy, load;
    issue_t                            pay_q [NFU];
    issue_t                            pay_d [NFU];
    logic [NFU-1:0][RS_SIZE-1:0]       cand, sel;
    logic [RS_SIZE-1:0]                rdy, fu_vec, alloc_oh, issue_oh;
    logic [CNT_W-1:0]                  n_issue;
    logic                              alloc_fire;
    entry_t                            new_ent;

    assign alloc_ready_o = (free_q != '0) && !flush_i;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign fu_rdy        = {mem_ready_i, alu_ready_i};

    for (genvar i = 0; i < RS_SIZE; i++) begin : g_ent
        assign rdy[i]    = busy_q[i] && (ent_q[i].op1.tag == '0) && (ent_q[i].op2.tag == '0);
        assign fu_vec[i] = ent_q[i].fu;
        for (genvar j = 0; j < RS_SIZE; j++) begin : g_col
            assign older_t[i][j] = older_q[j][i];
        end
    end

    // Oldest ready per FU: a candidate with no other candidate older than it.
    for (genvar f = 0; f < NFU; f++) begin : g_fu
        assign cand[f] = rdy & ((f == 0) ? ~fu_vec : fu_vec);
        for (genvar i = 0; i < RS_SIZE; i++) begin : g_sel
            assign sel[f][i] = cand[f][i] && !(|(cand[f] & older_t[i]));
        end
    end

    always_comb begin
        vld_d    = vld_q;
        load     = '0;
        issue_oh = '0;
        n_issue  = '0;
        for (int f = 0; f < NFU; f++) begin
            pay_d[f] = pay_q[f];
            if (!vld_q[f] || fu_rdy[f]) begin
                vld_d[f] = |sel[f];
                load[f]  = |sel[f];
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (sel[f][i])
                        pay_d[f] = '{tag: ent_q[i].tag, v1: ent_q[i].op1.val, v2: ent_q[i].op2.val,
                                     imm: ent_q[i].imm, ctrl: ent_q[i].ctrl};
                end
            end
            if (load[f]) begin
                issue_oh = issue_oh | sel[f];
                n_issue  = n_issue + CNT_W'(1);
            end
            if (flush_i) vld_d[f] = 1'b0;
        end
    end

    always_comb begin
        alloc_oh = '0;
        for (int i = RS_SIZE-1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alloc_oh    = '0;
                alloc_oh[i] = 1'b1;
            end
        end
        new_ent.fu   = alloc_fu_i;
        new_ent.tag  = alloc_tag_i;
        new_ent.op1  = snoop('{tag: alloc_tag_1_i, val: alloc_value_1_i},
                             cdb_tag_1_i, cdb_tag_2_i, cdb_value_1_i, cdb_value_2_i);
        new_ent.op2  = snoop('{tag: alloc_tag_2_i, val: alloc_value_2_i},
                             cdb_tag_1_i, cdb_tag_2_i, cdb_value_1_i, cdb_value_2_i);
        new_ent.imm  = alloc_imm_i;
        new_ent.ctrl = alloc_ctrl_i;
    end

    // Issue, wakeup and allocation all resolve against start-of-cycle state.
    always_comb begin
        busy_d  = busy_q & ~issue_oh;
        older_d = older_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = ent_q[i];
            if (busy_q[i]) begin
                ent_d[i].op1 = snoop(ent_q[i].op1, cdb_tag_1_i, cdb_tag_2_i, cdb_value_1_i, cdb_value_2_i);
                ent_d[i].op2 = snoop(ent_q[i].op2, cdb_tag_1_i, cdb_tag_2_i, cdb_value_1_i, cdb_value_2_i);
            end
            if (alloc_fire && alloc_oh[i]) begin
                ent_d[i]   = new_ent;
                busy_d[i]  = 1'b1;
                older_d[i] = '0;
                for (int j = 0; j < RS_SIZE; j++) older_d[j][i] = busy_q[j];
            end
        end
        if (flush_i) busy_d = '0;
        free_d = flush_i ? CNT_W'(RS_SIZE)
                         : free_q + n_issue - CNT_W'(alloc_fire);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_q  <= '0;
            older_q <= '0;
            free_q  <= CNT_W'(RS_SIZE);
            vld_q   <= '0;
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
            for (int f = 0; f < NFU; f++)     pay_q[f] <= '0;
        end else begin
            busy_q  <= busy_d;
            older_q <= older_d;
            free_q  <= free_d;
            vld_q   <= vld_d;
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
            for (int f = 0; f < NFU; f++)     pay_q[f] <= pay_d[f];
        end
    end

    assign free_count_o  = free_q;
    assign alu_valid_o   = vld_q[0];
    assign alu_tag_o     = pay_q[0].tag;
    assign alu_value_1_o = pay_q[0].v1;
    assign alu_value_2_o = pay_q[0].v2;
    assign alu_imm_o     = pay_q[0].imm;
    assign alu_ctrl_o    = pay_q[0].ctrl;
    assign mem_valid_o   = vld_q[1];
    assign mem_tag_o     = pay_q[1].tag;
    assign mem_value_1_o = pay_q[1].v1;
    assign mem_value_2_o = pay_q[1].v2;
    assign mem_imm_o     = pay_q[1].imm;
    assign mem_ctrl_o    = pay_q[1].ctrl;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: vector table for single-entry issue paths,
// hand sequences for wakeup timing, age ordering, full/flush and async reset.
module tb_rs_issue_scheduler;
    logic        clk, reset, flush;
    logic        alloc_valid, alloc_ready, alloc_fu;
    logic [5:0]  alloc_tag, alloc_tag_1, alloc_tag_2;
    logic [31:0] alloc_value_1, alloc_value_2, alloc_imm;
    logic [15:0] alloc_ctrl;
    logic [5:0]  cdb_tag_1, cdb_tag_2;
    logic [31:0] cdb_value_1, cdb_value_2;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [5:0]  alu_tag, mem_tag;
    logic [31:0] alu_v1, alu_v2, alu_imm, mem_v1, mem_v2, mem_imm;
    logic [15:0] alu_ctrl, mem_ctrl;
    logic [3:0]  free_count;

    int n_tests = 0;
    int n_fail  = 0;

    rs_issue_scheduler dut (
        .clk_i(clk), .reset_i(reset), .flush_i(flush),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_fu_i(alloc_fu),
        .alloc_tag_i(alloc_tag), .alloc_tag_1_i(alloc_tag_1), .alloc_tag_2_i(alloc_tag_2),
        .alloc_value_1_i(alloc_value_1), .alloc_value_2_i(alloc_value_2),
        .alloc_imm_i(alloc_imm), .alloc_ctrl_i(alloc_ctrl),
        .cdb_tag_1_i(cdb_tag_1), .cdb_tag_2_i(cdb_tag_2),
        .cdb_value_1_i(cdb_value_1), .cdb_value_2_i(cdb_value_2),
        .alu_valid_o(alu_valid), .alu_ready_i(alu_ready), .alu_tag_o(alu_tag),
        .alu_value_1_o(alu_v1), .alu_value_2_o(alu_v2), .alu_imm_o(alu_imm), .alu_ctrl_o(alu_ctrl),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_tag_o(mem_tag),
        .mem_value_1_o(mem_v1), .mem_value_2_o(mem_v2), .mem_imm_o(mem_imm), .mem_ctrl_o(mem_ctrl),
        .free_count_o(free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        fu;
        logic [5:0]  tag, t1, t2, c1t, c2t;
        logic [31:0] v1, v2, imm, c1v, c2v, ev1, ev2;
        logic [15:0] ctrl;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_cdb();
        cdb_tag_1 = '0; cdb_tag_2 = '0; cdb_value_1 = '0; cdb_value_2 = '0;
    endtask

    task automatic set_alloc(input logic fu, input logic [5:0] tag, input logic [5:0] t1,
                             input logic [31:0] v1, input logic [5:0] t2, input logic [31:0] v2);
        alloc_valid = 1'b1; alloc_fu = fu; alloc_tag = tag;
        alloc_tag_1 = t1; alloc_value_1 = v1; alloc_tag_2 = t2; alloc_value_2 = v2;
        alloc_imm = 32'h0; alloc_ctrl = 16'h0;
    endtask

    initial begin
        int n;
        reset = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_fu = 1'b0;
        alloc_tag = '0; alloc_tag_1 = '0; alloc_tag_2 = '0;
        alloc_value_1 = '0; alloc_value_2 = '0; alloc_imm = '0; alloc_ctrl = '0;
        alu_ready = 1'b1; mem_ready = 1'b1;
        clr_cdb();

        //                fu   tag    t1     t2    c1t   c2t   v1            v2     imm           c1v    c2v    ev1    ev2    ctrl
        vecs[0] = '{1'b0, 6'd5,  6'd0, 6'd0, 6'd0, 6'd0, 32'd3,        32'd4, 32'h10,       32'h0, 32'h0, 32'd3, 32'd4, 16'h1234};
        vecs[1] = '{1'b0, 6'd9,  6'd4, 6'd0, 6'd4, 6'd4, 32'hDEAD,     32'd7, 32'h20,       32'h11,32'h22,32'h11,32'd7, 16'h0001};
        vecs[2] = '{1'b1, 6'd12, 6'd0, 6'd8, 6'd3, 6'd8, 32'h55,       32'h0, 32'h30,       32'h99,32'h77,32'h55,32'h77,16'h00F0};
        vecs[3] = '{1'b1, 6'd63, 6'd6, 6'd7, 6'd7, 6'd6, 32'h0,        32'h0, 32'hFFFFFFFF, 32'hA1,32'hB2,32'hB2,32'hA1,16'hFFFF};
        vecs[4] = '{1'b0, 6'd1,  6'd2, 6'd2, 6'd2, 6'd0, 32'h0,        32'h0, 32'h0,        32'h5, 32'h0, 32'h5, 32'h5, 16'h8000};

        // Reset state
        tick(); tick();
        chk("rst_alu_valid", 64'(alu_valid), 64'd0);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_free", 64'(free_count), 64'd8);
        chk("rst_alu_tag", 64'(alu_tag), 64'd0);
        reset = 1'b0;
        tick();
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);

        // Table: single entry, both ports ready, issue one edge after acceptance
        for (int k = 0; k < 5; k++) begin
            chk("vec_alloc_ready", 64'(alloc_ready), 64'd1);
            alloc_valid = 1'b1; alloc_fu = vecs[k].fu; alloc_tag = vecs[k].tag;
            alloc_tag_1 = vecs[k].t1; alloc_value_1 = vecs[k].v1;
            alloc_tag_2 = vecs[k].t2; alloc_value_2 = vecs[k].v2;
            alloc_imm = vecs[k].imm; alloc_ctrl = vecs[k].ctrl;
            cdb_tag_1 = vecs[k].c1t; cdb_value_1 = vecs[k].c1v;
            cdb_tag_2 = vecs[k].c2t; cdb_value_2 = vecs[k].c2v;
            tick();
            alloc_valid = 1'b0; clr_cdb();
            chk("vec_valid_e0", 64'(vecs[k].fu ? mem_valid : alu_valid), 64'd0);
            chk("vec_free_e0", 64'(free_count), 64'd7);
            tick();
            chk("vec_valid_e1", 64'(vecs[k].fu ? mem_valid : alu_valid), 64'd1);
            chk("vec_other_valid", 64'(vecs[k].fu ? alu_valid : mem_valid), 64'd0);
            chk("vec_tag", 64'(vecs[k].fu ? mem_tag : alu_tag), 64'(vecs[k].tag));
            chk("vec_v1", 64'(vecs[k].fu ? mem_v1 : alu_v1), 64'(vecs[k].ev1));
            chk("vec_v2", 64'(vecs[k].fu ? mem_v2 : alu_v2), 64'(vecs[k].ev2));
            chk("vec_imm", 64'(vecs[k].fu ? mem_imm : alu_imm), 64'(vecs[k].imm));
            chk("vec_ctrl", 64'(vecs[k].fu ? mem_ctrl : alu_ctrl), 64'(vecs[k].ctrl));
            chk("vec_free_e1", 64'(free_count), 64'd8);
            tick();
            chk("vec_valid_drop", 64'(vecs[k].fu ? mem_valid : alu_valid), 64'd0);
        end

        // Wakeup via CDB port 2 one cycle after allocation
        set_alloc(1'b0, 6'd7, 6'd2, 32'h0, 6'd0, 32'h3);
        tick();
        alloc_valid = 1'b0;
        cdb_tag_2 = 6'd2; cdb_value_2 = 32'hAB;
        chk("wake_pre", 64'(alu_valid), 64'd0);
        tick();
        clr_cdb();
        chk("wake_c0", 64'(alu_valid), 64'd0);
        tick();
        chk("wake_valid", 64'(alu_valid), 64'd1);
        chk("wake_tag", 64'(alu_tag), 64'd7);
        chk("wake_v1", 64'(alu_v1), 64'hAB);
        chk("wake_v2", 64'(alu_v2), 64'h3);
        tick();

        // Age order: tags 1,2,3 wait; 3 and 1 wake together, then 2; ALU stalled
        alu_ready = 1'b0;
        set_alloc(1'b0, 6'd1, 6'd11, 32'h0, 6'd0, 32'h0); tick();
        set_alloc(1'b0, 6'd2, 6'd12, 32'h0, 6'd0, 32'h0); tick();
        set_alloc(1'b0, 6'd3, 6'd13, 32'h0, 6'd0, 32'h0); tick();
        alloc_valid = 1'b0;
        chk("age_free", 64'(free_count), 64'd5);
        cdb_tag_1 = 6'd13; cdb_value_1 = 32'h300; cdb_tag_2 = 6'd11; cdb_value_2 = 32'h100;
        tick();
        clr_cdb();
        cdb_tag_1 = 6'd12; cdb_value_1 = 32'h200;
        chk("age_valid_w1", 64'(alu_valid), 64'd0);
        tick();
        clr_cdb();
        chk("age_first_tag", 64'(alu_tag), 64'd1);
        chk("age_first_v1", 64'(alu_v1), 64'h100);
        tick();
        chk("age_hold1_tag", 64'(alu_tag), 64'd1);
        tick();
        chk("age_hold2_tag", 64'(alu_tag), 64'd1);
        chk("age_hold2_valid", 64'(alu_valid), 64'd1);
        alu_ready = 1'b1;
        tick();
        chk("age_second_tag", 64'(alu_tag), 64'd2);
        chk("age_second_v1", 64'(alu_v1), 64'h200);
        tick();
        chk("age_third_tag", 64'(alu_tag), 64'd3);
        chk("age_third_v1", 64'(alu_v1), 64'h300);
        tick();
        chk("age_drain_valid", 64'(alu_valid), 64'd0);
        chk("age_drain_free", 64'(free_count), 64'd8);

        // Fill: MEM stalled, allocator held valid until refused
        mem_ready = 1'b0;
        n = 0;
        set_alloc(1'b1, 6'd20, 6'd0, 32'h0, 6'd0, 32'h0);
        for (int c = 0; c < 20; c++) begin
            if (!alloc_ready) break;
            alloc_tag = 6'(20 + n);
            tick();
            n++;
        end
        chk("full_accepts", 64'(n), 64'd9);
        chk("full_free", 64'(free_count), 64'd0);
        chk("full_alloc_ready", 64'(alloc_ready), 64'd0);
        chk("full_mem_tag", 64'(mem_tag), 64'd20);
        alloc_tag = 6'd29;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("full_next_tag", 64'(mem_tag), 64'd21);
        chk("full_free_one", 64'(free_count), 64'd1);
        chk("full_ready_one", 64'(alloc_ready), 64'd1);
        tick();
        chk("full_refill_free", 64'(free_count), 64'd0);
        chk("full_refill_ready", 64'(alloc_ready), 64'd0);
        chk("full_stable_tag", 64'(mem_tag), 64'd21);
        alloc_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("full_flush_free", 64'(free_count), 64'd8);

        // Flush with MEM payload pending and five entries busy; alloc/CDB dropped
        for (int k = 0; k < 6; k++) begin
            set_alloc(1'b1, 6'(40 + k), 6'd0, 32'h0, 6'd0, 32'h0);
            tick();
        end
        alloc_valid = 1'b0;
        chk("fl_pre_free", 64'(free_count), 64'd3);
        chk("fl_pre_valid", 64'(mem_valid), 64'd1);
        chk("fl_pre_tag", 64'(mem_tag), 64'd40);
        set_alloc(1'b0, 6'd50, 6'd0, 32'h0, 6'd0, 32'h0);
        cdb_tag_1 = 6'd40; cdb_value_1 = 32'h1;
        flush = 1'b1;
        #1;
        chk("fl_alloc_ready", 64'(alloc_ready), 64'd0);
        tick();
        flush = 1'b0; alloc_valid = 1'b0; clr_cdb();
        chk("fl_mem_valid", 64'(mem_valid), 64'd0);
        chk("fl_free", 64'(free_count), 64'd8);
        tick();
        chk("fl_no_residue_mem", 64'(mem_valid), 64'd0);
        chk("fl_no_residue_alu", 64'(alu_valid), 64'd0);
        mem_ready = 1'b1;

        // Asynchronous reset mid-cycle with an ALU payload stalled
        alu_ready = 1'b0;
        set_alloc(1'b0, 6'd33, 6'd0, 32'h7, 6'd0, 32'h8);
        tick();
        set_alloc(1'b0, 6'd34, 6'd9, 32'h0, 6'd0, 32'h0);
        tick();
        alloc_valid = 1'b0;
        chk("ar_pre_valid", 64'(alu_valid), 64'd1);
        chk("ar_pre_free", 64'(free_count), 64'd7);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_alu_valid", 64'(alu_valid), 64'd0);
        chk("ar_alu_tag", 64'(alu_tag), 64'd0);
        chk("ar_free", 64'(free_count), 64'd8);
        tick();
        reset = 1'b0;
        alu_ready = 1'b1;
        tick();
        chk("ar_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("ar_after_valid", 64'(alu_valid), 64'd0);
        chk("ar_after_free", 64'(free_count), 64'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
